// File: rtl/vic_pkg.sv
// ---------------------------------------------------------------------------
// vic_pkg
//
// Shared types and constants for the VIC-II / 6510 bus arbiter.
//   arb_state_e            : phase-2 ownership state (CPU, WAIT, VIC)
//   PH1 / PH2              : encoding of the half-cycle phase register
//   P_STEAL_DELAY_DEFAULT  : default number of phase-2 cycles between BA and BM
//   ARB_CNT_W              : width of the steal-delay counter
// ---------------------------------------------------------------------------
package vic_pkg;

    typedef enum logic [1:0] {
        ARB_CPU  = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_VIC  = 2'd2
    } arb_state_e;

    localparam logic PH1 = 1'b0;
    localparam logic PH2 = 1'b1;

    localparam int unsigned P_STEAL_DELAY_DEFAULT = 3;

    // Steal delay must fit in this width.
    localparam int unsigned ARB_CNT_W = 8;

endpackage

// File: rtl/vic_bus_arb.sv
// ---------------------------------------------------------------------------
// vic_bus_arb
//
// Phase-interleaved arbiter for the shared memory bus between the VIC-II and
// the 6510 CPU. Phase 1 always belongs to the VIC-II; phase 2 belongs to the
// CPU unless the VIC-II steals it through BA/BM. Muxes the memory address,
// gates CPU writes, produces CPU RDY and latches read data per bus master.
//
// Optional feature macro: VIC_BUS_ARB_STATS_EN
//   When defined, adds i_stats_clr and o_stolen_cnt (count of phase-2 cycles
//   owned by the VIC-II, wraps at 16 bits, clear has priority).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   clk_1mhz_ph1_en     strobe closing phase 1
//   clk_1mhz_ph2_en     strobe closing phase 2
//   i_ba, i_bm          VIC bus-available / bus-master (active low)
//   i_vic_addr_ph1/ph2  VIC addresses for phase 1 / phase 2
//   i_cpu_addr/we/data  CPU bus request
//   o_cpu_rdy           CPU ready (registered, high only in state CPU)
//   o_cpu_data          latched CPU read data
//   o_vic_data_ph1/ph2  latched VIC read data for each phase
//   o_mem_addr/we/data  memory request
//   i_mem_data          memory read data {colour nibble, byte}, 1-clk latency
//   o_conflict          one-clk protocol-error pulse
// ---------------------------------------------------------------------------
module vic_bus_arb
    import vic_pkg::*;
#(
    parameter int unsigned P_STEAL_DELAY = P_STEAL_DELAY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1mhz_ph1_en,
    input  logic        clk_1mhz_ph2_en,
    input  logic        i_ba,
    input  logic        i_bm,
    input  logic [15:0] i_vic_addr_ph1,
    input  logic [15:0] i_vic_addr_ph2,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_cpu_data,
    output logic        o_cpu_rdy,
    output logic [7:0]  o_cpu_data,
    output logic [11:0] o_vic_data_ph1,
    output logic [11:0] o_vic_data_ph2,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_data,
    input  logic [11:0] i_mem_data,
`ifdef VIC_BUS_ARB_STATS_EN
    input  logic        i_stats_clr,
    output logic [15:0] o_stolen_cnt,
`endif
    output logic        o_conflict
);

    localparam logic [ARB_CNT_W-1:0] StealMax = ARB_CNT_W'(P_STEAL_DELAY);

    // -----------------------------------------------------------------------
    // Strobe decode. Coincident strobes are treated as phase-1 only, so the
    // phase-2 strobe is masked and the clash is flagged as a conflict.
    // -----------------------------------------------------------------------
    logic ph1_strb;
    logic ph2_strb;
    logic strb_clash;

    assign ph1_strb   = clk_1mhz_ph1_en;
    assign ph2_strb   = clk_1mhz_ph2_en & ~clk_1mhz_ph1_en;
    assign strb_clash = clk_1mhz_ph1_en & clk_1mhz_ph2_en;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_state_e           state_q, state_d;
    logic                 phase_q, phase_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 cpu_rdy_q;
    logic                 conflict_q, conflict_d;
    logic [7:0]           cpu_data_q;
    logic [11:0]          vic_data_ph1_q;
    logic [11:0]          vic_data_ph2_q;

    // Saturating increment of the steal-delay counter.
    logic [ARB_CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_q >= StealMax) ? cnt_q : cnt_q + 1'b1;

    // -----------------------------------------------------------------------
    // Phase register
    // -----------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        if (ph1_strb) begin
            phase_d = PH2;
        end else if (ph2_strb) begin
            phase_d = PH1;
        end
    end

    // -----------------------------------------------------------------------
    // Ownership state machine, evaluated only on the phase-2 strobe.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = strb_clash;

        if (ph2_strb) begin
            if (!i_bm) begin
                // VIC always wins phase 2, legal or not.
                state_d = ARB_VIC;
                case (state_q)
                    ARB_CPU: begin
                        conflict_d = 1'b1;
                    end
                    ARB_WAIT: begin
                        // cnt_inc includes the WAIT cycle this strobe closes, so
                        // the steal is legal once StealMax WAIT cycles elapsed.
                        if (i_ba || (cnt_inc < StealMax)) begin
                            conflict_d = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (!i_ba) begin
                state_d = ARB_WAIT;
                cnt_d   = (state_q == ARB_CPU) ? '0 : cnt_inc;
            end else begin
                state_d = ARB_CPU;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_CPU;
            phase_q        <= PH1;
            cnt_q          <= '0;
            cpu_rdy_q      <= 1'b1;
            conflict_q     <= 1'b0;
            cpu_data_q     <= '0;
            vic_data_ph1_q <= '0;
            vic_data_ph2_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            cpu_rdy_q  <= (state_d == ARB_CPU);
            conflict_q <= conflict_d;

            if (ph1_strb) begin
                vic_data_ph1_q <= i_mem_data;
            end

            if (ph2_strb) begin
                if (state_q == ARB_VIC) begin
                    vic_data_ph2_q <= i_mem_data;
                end else if (!i_cpu_we) begin
                    // Reads in WAIT are latched too; the CPU repeats them anyway.
                    cpu_data_q <= i_mem_data[7:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Address mux and write gating
    // -----------------------------------------------------------------------
    always_comb begin
        if (phase_q == PH1) begin
            o_mem_addr = i_vic_addr_ph1;
        end else if (state_q == ARB_VIC) begin
            o_mem_addr = i_vic_addr_ph2;
        end else begin
            o_mem_addr = i_cpu_addr;
        end
    end

    // Reset drops an in-flight write on the same clk.
    assign o_mem_we = ph2_strb & (phase_q == PH2) & (state_q != ARB_VIC) & i_cpu_we & ~rst;

    assign o_mem_data     = i_cpu_data;
    assign o_cpu_rdy      = cpu_rdy_q;
    assign o_conflict     = conflict_q;
    assign o_cpu_data     = cpu_data_q;
    assign o_vic_data_ph1 = vic_data_ph1_q;
    assign o_vic_data_ph2 = vic_data_ph2_q;

    // -----------------------------------------------------------------------
    // Optional steal statistics
    // -----------------------------------------------------------------------
`ifdef VIC_BUS_ARB_STATS_EN
    logic [15:0] stolen_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || i_stats_clr) begin
            stolen_cnt_q <= '0;
        end else if (ph2_strb && (state_q == ARB_VIC)) begin
            stolen_cnt_q <= stolen_cnt_q + 16'd1;
        end
    end

    assign o_stolen_cnt = stolen_cnt_q;
`endif

endmodule

// File: tb/tb_vic_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_vic_bus_arb
//
// Directed bench for vic_bus_arb: a small 12-bit memory model, bus-cycle
// tasks that produce ph1/ph2 strobes, and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_vic_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ph1_en;
    logic        ph2_en;
    logic        ba;
    logic        bm;
    logic [15:0] vic_a1;
    logic [15:0] vic_a2;
    logic [15:0] cpu_a;
    logic        cpu_we;
    logic [7:0]  cpu_wd;
    logic        cpu_rdy;
    logic [7:0]  cpu_rd;
    logic [11:0] vd1;
    logic [11:0] vd2;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_wd;
    logic [11:0] mem_rd;
    logic        conflict;
`ifdef VIC_BUS_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] stolen_cnt;
`endif

    always #5 clk = ~clk;

    vic_bus_arb #(
        .P_STEAL_DELAY(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_1mhz_ph1_en(ph1_en),
        .clk_1mhz_ph2_en(ph2_en),
        .i_ba           (ba),
        .i_bm           (bm),
        .i_vic_addr_ph1 (vic_a1),
        .i_vic_addr_ph2 (vic_a2),
        .i_cpu_addr     (cpu_a),
        .i_cpu_we       (cpu_we),
        .i_cpu_data     (cpu_wd),
        .o_cpu_rdy      (cpu_rdy),
        .o_cpu_data     (cpu_rd),
        .o_vic_data_ph1 (vd1),
        .o_vic_data_ph2 (vd2),
        .o_mem_addr     (mem_a),
        .o_mem_we       (mem_we),
        .o_mem_data     (mem_wd),
        .i_mem_data     (mem_rd),
`ifdef VIC_BUS_ARB_STATS_EN
        .i_stats_clr    (stats_clr),
        .o_stolen_cnt   (stolen_cnt),
`endif
        .o_conflict     (conflict)
    );

    // Memory model with bench preload port, plus event counters.
    logic [11:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_a;
    logic [11:0] pre_d;
    int          we_cnt   = 0;
    int          conf_cnt = 0;
    logic [15:0] we_addr  = '0;
    logic [15:0] ph2_addr = '0;

    always @(posedge clk) begin
        mem_rd <= mem[mem_a];
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (mem_we) begin
            mem[mem_a] <= {4'h0, mem_wd};
        end
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_a;
        end
        if (conflict) begin
            conf_cnt <= conf_cnt + 1;
        end
        if (ph2_en) begin
            ph2_addr <= mem_a;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [11:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Two settle clocks, then one strobe clock; returns at the negedge after it.
    task automatic ph_half(input bit is_ph2);
        @(negedge clk);
        @(negedge clk);
        if (is_ph2) ph2_en = 1'b1;
        else        ph1_en = 1'b1;
        @(negedge clk);
        ph1_en = 1'b0;
        ph2_en = 1'b0;
    endtask

    task automatic bus_cycle();
        ph_half(1'b0);
        ph_half(1'b1);
    endtask

    initial begin
        int w0;
        int c0;
        rst    = 1'b1;
        ph1_en = 1'b0;
        ph2_en = 1'b0;
        ba     = 1'b1;
        bm     = 1'b1;
        vic_a1 = 16'h1000;
        vic_a2 = 16'h2000;
        cpu_a  = 16'h0000;
        cpu_we = 1'b0;
        cpu_wd = 8'h00;
        pre_we = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
`ifdef VIC_BUS_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        preload(16'h1000, 12'hABC);
        for (int k = 0; k < 4; k++) begin
            preload(16'h2000 + 16'(k), 12'h300 + 12'(k));
        end
        preload(16'h2010, 12'h7E5);
        @(negedge clk);

        // Reset state
        check_eq("rst_rdy",      cpu_rdy,  1);
        check_eq("rst_conflict", conflict, 0);
        check_eq("rst_we",       mem_we,   0);
        check_eq("rst_cpu_data", cpu_rd,   0);
        check_eq("rst_vd1",      vd1,      0);
        check_eq("rst_vd2",      vd2,      0);
        check_eq("rst_addr_ph1", mem_a,    16'h1000);
        rst = 1'b0;

        // Idle bus: CPU writes 0x5A to 0x0400, one write per phase 2
        w0     = we_cnt;
        cpu_a  = 16'h0400;
        cpu_wd = 8'h5A;
        cpu_we = 1'b1;
        bus_cycle();
        check_eq("idle_we_cnt1", we_cnt - w0, 1);
        check_eq("idle_we_addr", we_addr,     16'h0400);
        check_eq("idle_ph2addr", ph2_addr,    16'h0400);
        check_eq("idle_vd1",     vd1,         12'hABC);
        check_eq("idle_rdy",     cpu_rdy,     1);
        bus_cycle();
        check_eq("idle_we_cnt2", we_cnt - w0, 2);
        cpu_we = 1'b0;
        bus_cycle();
        check_eq("idle_read",    cpu_rd,      8'h5A);
        check_eq("idle_rd_rdy",  cpu_rdy,     1);
        check_eq("idle_rd_nowe", we_cnt - w0, 2);

        // Bad line: BA low, BM low three strobes later
        w0     = we_cnt;
        c0     = conf_cnt;
        ba     = 1'b0;
        cpu_we = 1'b1;
        cpu_a  = 16'h0500;
        cpu_wd = 8'h11;
        bus_cycle();
        check_eq("bad_rdy_low",  cpu_rdy, 0);
        cpu_a  = 16'h0501;
        cpu_wd = 8'h22;
        bus_cycle();
        cpu_a  = 16'h0502;
        cpu_wd = 8'h33;
        bus_cycle();
        bm     = 1'b0;
        cpu_a  = 16'h0503;
        cpu_wd = 8'h44;
        bus_cycle();
        check_eq("bad_wait_we",  we_cnt - w0, 4);
        check_eq("bad_mem_0501", mem[16'h0501], 12'h022);
        check_eq("bad_mem_0503", mem[16'h0503], 12'h044);
        for (int k = 1; k < 3; k++) begin
            vic_a2 = 16'h2000 + 16'(k);
            bus_cycle();
            check_eq("bad_vd2",      vd2,      12'h300 + 12'(k));
            check_eq("bad_ph2addr",  ph2_addr, 16'h2000 + 16'(k));
        end
        check_eq("bad_vic_nowe", we_cnt - w0,   4);
        check_eq("bad_vic_rdy",  cpu_rdy,       0);
        check_eq("bad_noconf",   conf_cnt - c0, 0);
        ba     = 1'b1;
        bm     = 1'b1;
        cpu_we = 1'b0;
        bus_cycle();
        check_eq("bad_rdy_back", cpu_rdy, 1);

        // Early BM: one strobe after BA
        c0    = conf_cnt;
        ba    = 1'b0;
        cpu_a = 16'h0400;
        bus_cycle();
        bm     = 1'b0;
        vic_a2 = 16'h2010;
        bus_cycle();
        check_eq("early_conf_hi", conflict, 1);
        bus_cycle();
        check_eq("early_conf_1",  conf_cnt - c0, 1);
        check_eq("early_ph2addr", ph2_addr,      16'h2010);
        check_eq("early_vd2",     vd2,           12'h7E5);
        ba = 1'b1;
        bm = 1'b1;
        bus_cycle();
        check_eq("early_rdy_back", cpu_rdy, 1);

        // BM low while BA high, straight from CPU
        c0     = conf_cnt;
        bm     = 1'b0;
        vic_a2 = 16'h2001;
        bus_cycle();
        check_eq("bmba_conf_hi", conflict, 1);
        check_eq("bmba_rdy",     cpu_rdy,  0);
        bus_cycle();
        check_eq("bmba_ph2addr", ph2_addr,      16'h2001);
        check_eq("bmba_vd2",     vd2,           12'h301);
        check_eq("bmba_conf_1",  conf_cnt - c0, 1);
        bm = 1'b1;
        bus_cycle();
        check_eq("bmba_rdy_back", cpu_rdy, 1);

        // Long WAIT saturates the counter; late BM is legal
        c0 = conf_cnt;
        ba = 1'b0;
        repeat (5) bus_cycle();
        bm = 1'b0;
        bus_cycle();
        bus_cycle();
        check_eq("sat_noconf", conf_cnt - c0, 0);
        check_eq("sat_rdy",    cpu_rdy,       0);
        ba = 1'b1;
        bm = 1'b1;
        bus_cycle();

        // Coincident strobes: phase-1 only, plus a conflict pulse
        w0     = we_cnt;
        cpu_we = 1'b1;
        cpu_a  = 16'h0600;
        cpu_wd = 8'h66;
        @(negedge clk);
        @(negedge clk);
        ph1_en = 1'b1;
        ph2_en = 1'b1;
        @(negedge clk);
        ph1_en = 1'b0;
        ph2_en = 1'b0;
        check_eq("clash_conf",  conflict, 1);
        check_eq("clash_addr",  mem_a,    16'h0600);
        check_eq("clash_nowe",  we_cnt - w0, 0);
        ph_half(1'b1);
        check_eq("clash_we",    we_cnt - w0, 1);
        check_eq("clash_rdy",   cpu_rdy, 1);

        // Reset during a WAIT write cycle
        ba     = 1'b0;
        cpu_we = 1'b0;
        bus_cycle();
        check_eq("rstw_rdy_low", cpu_rdy, 0);
        w0     = we_cnt;
        cpu_we = 1'b1;
        cpu_a  = 16'h0700;
        ph_half(1'b0);
        @(negedge clk);
        @(negedge clk);
        ph2_en = 1'b1;
        rst    = 1'b1;
        #1;
        check_eq("rstw_we_drop", mem_we, 0);
        @(negedge clk);
        ph2_en = 1'b0;
        rst    = 1'b0;
        ba     = 1'b1;
        check_eq("rstw_rdy",   cpu_rdy,     1);
        check_eq("rstw_addr",  mem_a,       16'h1000);
        check_eq("rstw_nowe",  we_cnt - w0, 0);
        check_eq("rstw_noconf", conflict,   0);

`ifdef VIC_BUS_ARB_STATS_EN
        // 40-cycle steal, then clear coinciding with a steal strobe
        cpu_we    = 1'b0;
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        ba        = 1'b0;
        bm        = 1'b0;
        bus_cycle();
        repeat (40) bus_cycle();
        check_eq("stats_40", stolen_cnt, 40);
        ph_half(1'b0);
        @(negedge clk);
        @(negedge clk);
        ph2_en    = 1'b1;
        stats_clr = 1'b1;
        @(negedge clk);
        ph2_en    = 1'b0;
        stats_clr = 1'b0;
        check_eq("stats_clr", stolen_cnt, 0);
        ba = 1'b1;
        bm = 1'b1;
        bus_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vic_bus_arb.md
# vic_bus_arb

Phase-interleaved arbiter for the single shared memory bus between the VIC-II and the 6510 CPU. Phase 1 always belongs to the VIC-II. Phase 2 belongs to the CPU unless the VIC-II steals it using its BA/BM outputs. The block muxes addresses, gates CPU writes, generates CPU RDY and latches read data for each bus master. It sits between `vic_ii`, the CPU core and the main/colour RAM.

## Interface
Parameters:
- `P_STEAL_DELAY`, default 3: number of phase-2 cycles between BA falling and BM falling. During these cycles CPU writes are still honoured.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `clk_1mhz_ph1_en`  in  1  strobe ending phase 1
- `clk_1mhz_ph2_en`  in  1  strobe ending phase 2; strobes are at least 2 clk apart
- `i_ba`  in  1  VIC bus-available (low = steal pending)
- `i_bm`  in  1  VIC bus-master (low = VIC owns phase 2)
- `i_vic_addr_ph1`  in  16  VIC phase-1 address
- `i_vic_addr_ph2`  in  16  VIC phase-2 address
- `i_cpu_addr`  in  16  CPU address
- `i_cpu_we`  in  1  CPU write request
- `i_cpu_data`  in  8  CPU write data
- `o_cpu_rdy`  out  1  CPU ready
- `o_cpu_data`  out  8  latched CPU read data
- `o_vic_data_ph1`  out  12  latched phase-1 data to VIC
- `o_vic_data_ph2`  out  12  latched phase-2 data to VIC
- `o_mem_addr`  out  16  memory address
- `o_mem_we`  out  1  memory write strobe
- `o_mem_data`  out  8  memory write data
- `i_mem_data`  in  12  memory read data ({colour nibble, byte}); 1-clk read latency
- `o_conflict`  out  1  one-clk protocol-error pulse

## Operation
- Phase register `phase`:
  - becomes PH2 on the clk after `clk_1mhz_ph1_en`;
  - becomes PH1 on the clk after `clk_1mhz_ph2_en`.
- Address mux (combinational):
  - PH1: `o_mem_addr = i_vic_addr_ph1`.
  - PH2 in state VIC: `o_mem_addr = i_vic_addr_ph2`.
  - PH2 otherwise: `o_mem_addr = i_cpu_addr`.
- State machine. Transitions are evaluated only on `clk_1mhz_ph2_en`, using the current `i_ba`/`i_bm`.
  - CPU: entered when `i_ba=1`, `i_bm=1`.
  - WAIT: entered when `i_ba=0`, `i_bm=1`. `cnt` increments, saturating at `P_STEAL_DELAY`. `cnt` clears on entry from CPU.
  - VIC: entered when `i_bm=0`.
- Conflict conditions. Each causes a one-clk `o_conflict` pulse; VIC always wins phase 2.
  - CPU→VIC directly, i.e. BM low while BA high.
  - WAIT→VIC with `cnt < P_STEAL_DELAY`.
- `o_cpu_rdy = (state == CPU)` (registered state; no combinational path from `i_ba`).
- `o_mem_we` is high only on the clk where all of the following hold: `clk_1mhz_ph2_en`, phase PH2, state ≠ VIC, `i_cpu_we`. `o_mem_data = i_cpu_data`.
- Read-data latches:
  - On `clk_1mhz_ph1_en`: `o_vic_data_ph1 <= i_mem_data`.
  - On `clk_1mhz_ph2_en` in VIC: `o_vic_data_ph2 <= i_mem_data`.
  - On `clk_1mhz_ph2_en` otherwise, when `!i_cpu_we`: `o_cpu_data <= i_mem_data[7:0]`.
- Reads in WAIT are still performed and latched. The CPU repeats them because RDY is low.

## Timing
- Reset values:
  - state CPU, phase PH1, `cnt` 0;
  - `o_cpu_rdy` 1, `o_conflict` 0, `o_mem_we` 0;
  - all data latches 0.
- Read latency: the address must be stable at least 1 clk before the closing strobe. Data is visible on the latch output the clk after the strobe.
- `o_cpu_rdy` falls one clk after the `clk_1mhz_ph2_en` that samples `i_ba=0`. It rises one clk after the strobe that samples `i_ba=1` and `i_bm=1`.
- Both phase strobes in the same clk: treated as ph1 only, plus an `o_conflict` pulse.
- Reset mid-cycle: any in-flight write is dropped (`o_mem_we` 0 on the reset clk).

## Configuration
- `VIC_BUS_ARB_STATS_EN` defined: adds input `i_stats_clr` (1) and output `o_stolen_cnt` (16).
  - `o_stolen_cnt` increments on each `clk_1mhz_ph2_en` in state VIC and wraps at 0xFFFF→0.
  - It is cleared by `rst` or `i_stats_clr`; clear has priority over increment.
- Undefined: neither port nor the counter exists.

## Structure
- Shared package `vic_pkg`:
  - state enum (`ARB_CPU`, `ARB_WAIT`, `ARB_VIC`);
  - phase constants `PH1`/`PH2`;
  - default `P_STEAL_DELAY`.
- Single flat module. The optional stats counter is inline; no sub-module.

## Test plan
- Idle bus: BA=BM=1, CPU writes 0x5A to 0x0400 → `o_mem_we` pulses once per ph2 with `o_mem_addr` 0x0400. A following CPU read → `o_cpu_data` = 0x5A, `o_cpu_rdy` stays 1.
- Bad line: drop BA, then BM 3 ph2 strobes later → RDY low after the first strobe. CPU writes honoured in the 3 WAIT cycles. No writes once in VIC; `o_vic_data_ph2` tracks `i_vic_addr_ph2`. No `o_conflict`.
- Early BM: BM falls 1 strobe after BA → `o_conflict` pulses once; the VIC address drives phase 2.
- BM low with BA high → `o_conflict` pulse; state VIC.
- Reset asserted during a WAIT write cycle → `o_mem_we` 0, `o_cpu_rdy` 1, state CPU.
- With `VIC_BUS_ARB_STATS_EN`: 40-cycle steal → `o_stolen_cnt` = 40. Assert `i_stats_clr` together with a steal strobe → 0.
